// File: rtl/digit_canvas_buffer_pkg.sv
// canvas_pkg: shared constants, clear-FSM state encoding and the cell address
// helper for the digit canvas buffer (28x28 cells, 4-bit gray each).
package canvas_pkg;

    localparam int unsigned CANVAS_DIM   = 28;
    localparam int unsigned CANVAS_CELLS = 784;
    localparam int unsigned CELL_W       = 4;
    localparam int unsigned COORD_W      = 5;
    localparam int unsigned ADDR_W       = 10;

    localparam logic [CELL_W-1:0] GRID_GRAY = 4'h3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clrState_t;

    // Row-major cell address: y*28 + x.
    function automatic logic [ADDR_W-1:0] cellAddr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(CANVAS_DIM) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/digit_canvas_buffer_if.sv
// digit_canvas_buffer_if: write, clear and pixel-read signals of the canvas.
//   write : iWrValid/oWrReady handshake, iWrX/iWrY cell, iWrPix gray
//   clear : iClrReq pulse, oClrBusy status
//   read  : iRdEn with iPixX/iPixY screen coordinate, oRdValid/oGray result
// slave modport is the buffer side, master modport the client side.
interface digit_canvas_buffer_if;

    logic       iWrValid;
    logic [4:0] iWrX;
    logic [4:0] iWrY;
    logic [3:0] iWrPix;
    logic       oWrReady;
    logic       iClrReq;
    logic       oClrBusy;
    logic       iRdEn;
    logic [9:0] iPixX;
    logic [9:0] iPixY;
    logic       oRdValid;
    logic [3:0] oGray;

    modport slave (
        input  iWrValid, iWrX, iWrY, iWrPix, iClrReq, iRdEn, iPixX, iPixY,
        output oWrReady, oClrBusy, oRdValid, oGray
    );

    modport master (
        output iWrValid, iWrX, iWrY, iWrPix, iClrReq, iRdEn, iPixX, iPixY,
        input  oWrReady, oClrBusy, oRdValid, oGray
    );

endinterface

// File: rtl/digit_canvas_buffer_ram.sv
// canvas_ram: 784x4 cell storage, one synchronous write port and one
// synchronous read port. A read and write to the same address on the same
// edge returns the previous contents. Contents are not reset.
//   clk, wrEn/wrAddr/wrData (write port), rdAddr -> rdData (one-cycle read)
module canvas_ram
    import canvas_pkg::*;
(
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [CELL_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [CELL_W-1:0] rdData
);

    logic [CELL_W-1:0] mem [CANVAS_CELLS];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/digit_canvas_buffer.sv
// digit_canvas_buffer: 28x28 4-bit canvas written cell-by-cell and read as a
// scaled screen window with a 2-cycle pixel pipeline; a clear FSM zeroes all
// cells one per cycle (785 cycles of busy).
//   iBusClk : clock, all logic on rising edge
//   iRstN   : asynchronous active-low reset
//   bus     : digit_canvas_buffer_if.slave (write / clear / read signals)
// Optional build macro CANVAS_GRID_EN: in-window pixels on a cell boundary
// are lifted to at least GRID_GRAY to draw a grid.
module digit_canvas_buffer
    import canvas_pkg::*;
#(
    parameter int unsigned       ORIGIN_X   = 96,
    parameter int unsigned       ORIGIN_Y   = 16,
    parameter int unsigned       SCALE_LOG2 = 4,
    parameter logic [CELL_W-1:0] BG_GRAY    = 4'h1
) (
    input  logic                  iBusClk,
    input  logic                  iRstN,
    digit_canvas_buffer_if.slave  bus
);

    localparam int unsigned WIN = CANVAS_DIM << SCALE_LOG2;

    clrState_t         state, stateNext;
    logic [ADDR_W-1:0] clrAddr, clrAddrNext;
    logic              readyReg;
    logic              wrReady;
    logic              ramWe;
    logic [ADDR_W-1:0] ramWrAddr;
    logic [CELL_W-1:0] ramWrData;
    logic [ADDR_W-1:0] ramRdAddr;
    logic [CELL_W-1:0] ramRdData;

    logic [10:0]        offX, offY;
    logic               inWin;
    logic               s1Valid, s1InWin;
    logic               rdValid;
    logic [CELL_W-1:0]  gray, cellGray;

    // ---------------- clear FSM ----------------
    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= IDLE;
            clrAddr  <= '0;
            readyReg <= 1'b0;
        end else begin
            state    <= stateNext;
            clrAddr  <= clrAddrNext;
            readyReg <= 1'b1;
        end
    end

    always_comb begin
        stateNext   = state;
        clrAddrNext = clrAddr;
        case (state)
            IDLE: begin
                clrAddrNext = '0;
                if (bus.iClrReq) stateNext = CLEAR;
            end
            CLEAR: begin
                if (clrAddr == ADDR_W'(CANVAS_CELLS - 1)) begin
                    stateNext   = DONE;
                    clrAddrNext = '0;
                end else begin
                    clrAddrNext = clrAddr + 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A clear request in the same cycle takes priority over a pending write.
    assign wrReady = readyReg && (state == IDLE) && !bus.iClrReq;

    // The clear owns the write port while active; writes are blocked then.
    always_comb begin
        ramWe     = 1'b0;
        ramWrAddr = cellAddr(bus.iWrX, bus.iWrY);
        ramWrData = bus.iWrPix;
        if (state == CLEAR) begin
            ramWe     = 1'b1;
            ramWrAddr = clrAddr;
            ramWrData = '0;
        end else if (wrReady && bus.iWrValid &&
                     bus.iWrX < COORD_W'(CANVAS_DIM) &&
                     bus.iWrY < COORD_W'(CANVAS_DIM)) begin
            ramWe = 1'b1;
        end
    end

    // ---------------- read pipeline ----------------
    // Offsets are computed one bit wider so coordinates left of / above the
    // origin are rejected by the explicit >= test rather than wrapping.
    assign offX  = {1'b0, bus.iPixX} - 11'(ORIGIN_X);
    assign offY  = {1'b0, bus.iPixY} - 11'(ORIGIN_Y);
    assign inWin = ({1'b0, bus.iPixX} >= 11'(ORIGIN_X)) && (offX < 11'(WIN)) &&
                   ({1'b0, bus.iPixY} >= 11'(ORIGIN_Y)) && (offY < 11'(WIN));

    assign ramRdAddr = inWin ? cellAddr(COORD_W'(offX >> SCALE_LOG2),
                                        COORD_W'(offY >> SCALE_LOG2)) : '0;

    canvas_ram uRam (
        .clk    (iBusClk),
        .wrEn   (ramWe),
        .wrAddr (ramWrAddr),
        .wrData (ramWrData),
        .rdAddr (ramRdAddr),
        .rdData (ramRdData)
    );

`ifdef CANVAS_GRID_EN
    localparam logic [10:0] SUB_MASK = 11'((1 << SCALE_LOG2) - 1);
    logic s1Grid;

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) s1Grid <= 1'b0;
        else        s1Grid <= ((offX & SUB_MASK) == '0) || ((offY & SUB_MASK) == '0);
    end

    always_comb begin
        cellGray = ramRdData;
        if (s1Grid && ramRdData < GRID_GRAY) cellGray = GRID_GRAY;
    end
`else
    assign cellGray = ramRdData;
`endif

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            s1Valid <= 1'b0;
            s1InWin <= 1'b0;
            rdValid <= 1'b0;
            gray    <= '0;
        end else begin
            s1Valid <= bus.iRdEn;
            s1InWin <= inWin;
            rdValid <= s1Valid;
            if (s1Valid) gray <= s1InWin ? cellGray : BG_GRAY;
        end
    end

    assign bus.oWrReady = wrReady;
    assign bus.oClrBusy = (state != IDLE);
    assign bus.oRdValid = rdValid;
    assign bus.oGray    = gray;

endmodule

// File: tb/tb_digit_canvas_buffer.sv
// Testbench for digit_canvas_buffer: directed stimulus, expected read results
// queued at issue time and checked by an independent monitor on the falling
// edge (value and exact 2-cycle latency).
module tb_digit_canvas_buffer;

    localparam int unsigned OX = 96;
    localparam int unsigned OY = 16;
    localparam logic [3:0]  BG = 4'h1;

    typedef struct {
        logic [3:0]  gray;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rstN;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t q[$];
    logic [3:0] model [784];

    digit_canvas_buffer_if bus ();

    digit_canvas_buffer #(
        .ORIGIN_X   (OX),
        .ORIGIN_Y   (OY),
        .SCALE_LOG2 (4),
        .BG_GRAY    (BG)
    ) dut (
        .iBusClk (clk),
        .iRstN   (rstN),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every oRdValid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.oRdValid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdUnexpectedValid actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rdGray", bus.oGray, e.gray);
                check("rdLatency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unsigned x, input int unsigned y, input logic [3:0] pix);
        int unsigned n = 0;
        while (bus.oWrReady !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("wrReadyTimeout", 0, 1);
        bus.iWrValid = 1'b1;
        bus.iWrX = 5'(x);
        bus.iWrY = 5'(y);
        bus.iWrPix = pix;
        tick();
        bus.iWrValid = 1'b0;
        if (x < 28 && y < 28) model[y*28 + x] = pix;
    endtask

    task automatic rdPix(input int unsigned x, input int unsigned y, input logic [3:0] exp);
        bus.iRdEn = 1'b1;
        bus.iPixX = 10'(x);
        bus.iPixY = 10'(y);
        q.push_back('{gray: exp, cyc: cyc + 2});
        tick();
        bus.iRdEn = 1'b0;
    endtask

    task automatic rdCell(input int unsigned cx, input int unsigned cy);
        rdPix(OX + cx*16 + 8, OY + cy*16 + 8, model[cy*28 + cx]);
    endtask

    task automatic readAll();
        for (int unsigned y = 0; y < 28; y++)
            for (int unsigned x = 0; x < 28; x++)
                rdCell(x, y);
    endtask

    task automatic fillAll(input logic [3:0] pix);
        for (int unsigned y = 0; y < 28; y++)
            for (int unsigned x = 0; x < 28; x++)
                wr(x, y, pix);
    endtask

    initial begin
        int unsigned n, busyN, lowN;
        rstN = 1'b0;
        bus.iWrValid = 1'b0;
        bus.iWrX = '0;
        bus.iWrY = '0;
        bus.iWrPix = '0;
        bus.iClrReq = 1'b0;
        bus.iRdEn = 1'b0;
        bus.iPixX = '0;
        bus.iPixY = '0;

        // Reset state
        #12;
        check("rstWrReady", bus.oWrReady, 0);
        check("rstRdValid", bus.oRdValid, 0);
        check("rstGray", bus.oGray, 0);
        check("rstClrBusy", bus.oClrBusy, 0);
        #10 rstN = 1'b1;
        #1 check("wrReadyBeforeEdge", bus.oWrReady, 0);
        tick();
        check("wrReadyAfterEdge", bus.oWrReady, 1);

        // Basic write then scaled read of its cell
        wr(3, 5, 4'hF);
        rdPix(OX + 48, OY + 80, 4'hF);

        // Outside the window, including just below/left of the origin
        rdPix(0, 0, BG);
        rdPix(OX + 448, OY, BG);
        rdPix(OX - 1, OY + 80, BG);
        rdPix(OX + 48, OY - 1, BG);
        rdPix(OX + 48, OY + 448, BG);

        // Same-cycle read and write of one cell returns the old value
        bus.iWrValid = 1'b1;
        bus.iWrX = 5'd3;
        bus.iWrY = 5'd5;
        bus.iWrPix = 4'h2;
        bus.iRdEn = 1'b1;
        bus.iPixX = 10'(OX + 48);
        bus.iPixY = 10'(OY + 80);
        q.push_back('{gray: 4'hF, cyc: cyc + 2});
        tick();
        bus.iWrValid = 1'b0;
        bus.iRdEn = 1'b0;
        model[5*28 + 3] = 4'h2;
        rdPix(OX + 48, OY + 80, 4'h2);

        // Fill, then out-of-range writes are consumed without effect
        fillAll(4'hA);
        check("wrReadyOob", bus.oWrReady, 1);
        wr(28, 0, 4'h9);
        wr(0, 28, 4'h9);
        wr(31, 31, 4'h9);
        readAll();
        rdPix(OX + 447, OY + 447, 4'hA);

        // Clear with a colliding write; second request mid-clear is ignored
        bus.iClrReq = 1'b1;
        bus.iWrValid = 1'b1;
        bus.iWrX = '0;
        bus.iWrY = '0;
        bus.iWrPix = 4'h7;
        #1 check("wrReadyClrSameCycle", bus.oWrReady, 0);
        tick();
        bus.iClrReq = 1'b0;
        bus.iWrValid = 1'b0;
        n = 0;
        busyN = 0;
        lowN = 0;
        while (bus.oWrReady !== 1'b1 && n < 2000) begin
            if (bus.oClrBusy === 1'b1) busyN++;
            lowN++;
            bus.iClrReq = (n == 100);
            tick();
            n++;
        end
        bus.iClrReq = 1'b0;
        check("clrBusyCycles", busyN, 785);
        check("clrReadyLowCycles", lowN, 785);
        check("clrBusyAfter", bus.oClrBusy, 0);
        for (int unsigned i = 0; i < 784; i++) model[i] = 4'h0;
        readAll();

        // Reset at clear address 400 with a read in flight
        fillAll(4'hA);
        bus.iClrReq = 1'b1;
        tick();
        bus.iClrReq = 1'b0;
        repeat (399) tick();
        bus.iRdEn = 1'b1;
        bus.iPixX = '0;
        bus.iPixY = '0;
        tick();
        bus.iRdEn = 1'b0;
        rstN = 1'b0;
        #1;
        check("midRstRdValid", bus.oRdValid, 0);
        check("midRstClrBusy", bus.oClrBusy, 0);
        check("midRstWrReady", bus.oWrReady, 0);
        #1 rstN = 1'b1;
        tick();
        check("postRstClrBusy", bus.oClrBusy, 0);
        check("postRstWrReady", bus.oWrReady, 1);
        for (int unsigned i = 0; i < 400; i++) model[i] = 4'h0;
        readAll();

        repeat (4) tick();
        check("scoreboardDrain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
